obi_mem_responder: RTL and testbench
====================================

Name: obi_mem_responder

Overview:
Single-port OBI-style memory responder: the memory-side end of the core's data (or instruction) req/gnt/rvalid interface. Accepts requests, grants them, performs word-wide SRAM reads and byte-enabled writes, and returns in-order responses after a fixed latency. Flags an error for any access outside its address window. Used as the tightly-coupled data memory model and as the bench responder for core-level integration.

Parameters:
NumWords, 1024, memory depth in 32-bit words (power of two, >= 4)
BaseAddr, 32'h0000_0000, byte base address of the window (aligned to NumWords*4)
RespLatency, 1, cycles from grant to rvalid (1..4)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
data_req_i  input  1  request valid from initiator
data_gnt_o  output  1  request accepted this cycle
data_we_i  input  1  1 = write, 0 = read
data_be_i  input  4  byte enables
data_addr_i  input  32  byte address; bits [1:0] ignored
data_wdata_i  input  32  write data
data_rvalid_o  output  1  response valid
data_rdata_o  output  32  read data; 0 for writes and errors
data_err_o  output  1  error response, qualified by rvalid
stall_i  input  1  1 = withhold grant (back-pressure injection)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0. All response-pipeline stages are cleared.
- Memory contents are not reset.
- Grant: data_gnt_o = data_req_i & ~stall_i & ~rst_i. It is combinational and has no dependency on response state.
  - The pipeline is fully pipelined: one request per cycle is sustained.
  - In-flight requests never exceed RespLatency.
- Transfer: occurs on a cycle with req & gnt. The address, we, be and wdata fields are sampled only in that cycle.
- Address decode:
  - in_range = (data_addr_i - BaseAddr) < NumWords*4, computed as unsigned 32-bit subtraction so that wrap below BaseAddr is out of range.
  - Word index = (data_addr_i - BaseAddr)[log2(NumWords)+1:2].
- Write, in range: bytes with be[i]=1 are updated from wdata[8i+7:8i] at the clock edge ending the grant cycle. Bytes with be=0 are unchanged. be=4'b0000 is legal and is a no-op write with a normal response.
- Read, in range: the data word is the memory content before any write granted in the same cycle; only one transfer per cycle is possible. A read granted the cycle after a write observes the written data.
  - Read data ignores be: the full word is returned.
- Out of range: no memory access occurs. The response carries err=1 and rdata=0.
- Response pipeline:
  - RespLatency stages, each holding {valid, err, rdata}.
  - Stage 0 is loaded at the grant edge. Each subsequent stage shifts every cycle.
  - The outputs are driven from the last stage registers.
  - Grant in cycle N gives rvalid=1 in cycle N+RespLatency for exactly one cycle.
  - Order is preserved; rvalid has no back-pressure.
- Writes return rvalid with rdata=0 and err = ~in_range.
- When rvalid=0: rdata=0 and err=0.
- Reset mid-operation: in-flight responses are discarded and no rvalid is produced after reset. A write granted in the same cycle that rst_i=1 is impossible, because gnt is forced to 0.
- stall_i asserted while req=1: gnt stays 0. The initiator holds its fields. In-flight responses still drain on schedule.
- Simultaneous stall release and req: grant occurs in that same cycle.

Test Plan:
- Reset then idle: rst_i=1 for 2 cycles, req=0 -> gnt, rvalid, err, rdata all 0 throughout.
- Write then read back, RespLatency=1, BaseAddr=0:
  - Stimulus: write addr 0x10, be=4'hF, wdata=0xDEADBEEF; next cycle read addr 0x10.
  - Required: write response rvalid=1, err=0, rdata=0 one cycle after its grant; read response rdata=0xDEADBEEF one cycle after its grant.
- Partial write: preload 0x11223344 at 0x20; write be=4'b0101, wdata=0xAABBCCDD; read 0x20 -> rdata=0x11BB33DD.
- Out-of-range, NumWords=1024, BaseAddr=0x1000:
  - Read 0x2000 -> rvalid, err=1, rdata=0.
  - Read 0x0FFC -> err=1.
  - Write 0x2000 -> err=1 and memory unchanged (verified by readback).
- Back-to-back with RespLatency=3: 5 consecutive granted reads of 0x0,0x4,0x8,0xC,0x10 in cycles 0-4 -> rvalid in cycles 3-7 with data in the same order.
- Stall and reset:
  - stall_i=1 for 3 cycles with req=1 -> gnt=0 for those cycles, then gnt=1 on release.
  - With 2 responses in flight (RespLatency=3), pulse rst_i -> no rvalid afterward.
  - Memory contents are retained, checked by readback.

Source files
------------

// File: rtl/obi_mem_responder.sv
// ---------------------------------------------------------------------------
// obi_mem_responder
//   Memory-side end of an OBI-style req/gnt/rvalid interface. Grants any
//   request unless stalled or in reset. Reads return the full word. Writes
//   are byte-enabled. Responses come back in order after RespLatency cycles.
//   Accesses outside the address window get an error response and do not
//   touch memory.
//
// Parameters
//   NumWords    : memory depth in 32-bit words (power of two, >= 4)
//   BaseAddr    : byte base address of the window (aligned to NumWords*4)
//   RespLatency : cycles from grant to rvalid (1..4)
//
// Ports
//   clk_i         in   clock
//   rst_i         in   synchronous active-high reset
//   data_req_i    in   request valid
//   data_gnt_o    out  request accepted this cycle (combinational)
//   data_we_i     in   1 = write, 0 = read
//   data_be_i     in   [3:0] byte enables (writes only)
//   data_addr_i   in   [31:0] byte address, bits [1:0] ignored
//   data_wdata_i  in   [31:0] write data
//   data_rvalid_o out  response valid (one cycle per granted request)
//   data_rdata_o  out  [31:0] read data, 0 for writes/errors/idle
//   data_err_o    out  error response, qualified by rvalid
//   stall_i       in   withhold grant (back-pressure injection)
// ---------------------------------------------------------------------------
module obi_mem_responder #(
  parameter int          NumWords    = 1024,
  parameter logic [31:0] BaseAddr    = 32'h0000_0000,
  parameter int          RespLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  input  logic        stall_i
);

  localparam int          IdxW     = $clog2(NumWords);
  localparam logic [31:0] WinBytes = 32'(NumWords * 4);

  logic [31:0]     w_offset;
  logic            w_in_range;
  logic [IdxW-1:0] w_idx;
  logic            w_xfer;
  logic            w_wr;
  logic [31:0]     w_rd_word;
  logic [31:0]     w_s0_rdata;

  logic [31:0]            r_mem [NumWords];
  logic [RespLatency-1:0] r_vld;
  logic [RespLatency-1:0] r_err;
  logic [31:0]            r_rdata [RespLatency];

  // Unsigned subtraction: addresses below BaseAddr wrap to huge offsets and
  // therefore fall out of range without a separate lower-bound compare.
  assign w_offset   = data_addr_i - BaseAddr;
  assign w_in_range = (w_offset < WinBytes);
  assign w_idx      = w_offset[IdxW+1:2];

  // Grant never looks at response state, so one request per cycle sustains.
  assign data_gnt_o = data_req_i & ~stall_i & ~rst_i;
  assign w_xfer     = data_req_i & data_gnt_o;
  assign w_wr       = w_xfer & data_we_i & w_in_range;

  // Combinational read of the pre-write word; the write lands at the same
  // edge that loads stage 0, so same-cycle reads see old data.
  assign w_rd_word  = r_mem[w_idx];
  assign w_s0_rdata = (w_xfer & ~data_we_i & w_in_range) ? w_rd_word : 32'h0000_0000;

  // Byte-enabled memory write; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (w_wr && data_be_i[b]) begin
        r_mem[w_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
  end

  // Response pipeline: stage 0 captures the granted access, later stages
  // shift every cycle. Invalid stages carry zero data and zero err.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < RespLatency; i++) begin
        r_rdata[i] <= 32'h0000_0000;
      end
    end else begin
      r_vld[0]   <= w_xfer;
      r_err[0]   <= w_xfer & ~w_in_range;
      r_rdata[0] <= w_s0_rdata;
      for (int i = 1; i < RespLatency; i++) begin
        r_vld[i]   <= r_vld[i-1];
        r_err[i]   <= r_err[i-1];
        r_rdata[i] <= r_rdata[i-1];
      end
    end
  end

  assign data_rvalid_o = r_vld[RespLatency-1];
  assign data_err_o    = r_err[RespLatency-1];
  assign data_rdata_o  = r_rdata[RespLatency-1];

endmodule

// File: tb/tb_obi_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_obi_mem_responder
//   Directed bench. Three responders share one stimulus bus:
//     u_a : BaseAddr 0,      RespLatency 1
//     u_b : BaseAddr 0x1000, RespLatency 1 (window/error checks)
//     u_c : BaseAddr 0,      RespLatency 3 (pipelining/reset checks)
//   Each scenario checks only the instance it targets. Inputs are driven
//   1ns after the rising edge and outputs sampled shortly after.
// ---------------------------------------------------------------------------
module tb_obi_mem_responder;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;

  logic        gnt_a, rv_a, er_a;
  logic [31:0] rd_a;
  logic        gnt_b, rv_b, er_b;
  logic [31:0] rd_b;
  logic        gnt_c, rv_c, er_c;
  logic [31:0] rd_c;

  int n_vec = 0;
  int n_bad = 0;

  obi_mem_responder #(.NumWords(1024), .BaseAddr(32'h0000_0000), .RespLatency(1)) u_a (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt_a),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rvalid_o(rv_a), .data_rdata_o(rd_a), .data_err_o(er_a), .stall_i(stall)
  );

  obi_mem_responder #(.NumWords(1024), .BaseAddr(32'h0000_1000), .RespLatency(1)) u_b (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt_b),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rvalid_o(rv_b), .data_rdata_o(rd_b), .data_err_o(er_b), .stall_i(stall)
  );

  obi_mem_responder #(.NumWords(1024), .BaseAddr(32'h0000_0000), .RespLatency(3)) u_c (
    .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt_c),
    .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rvalid_o(rv_c), .data_rdata_o(rd_c), .data_err_o(er_c), .stall_i(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, confirm it is granted, advance past the grant edge.
  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    #1;
    check_vec("gnt", {31'd0, gnt_a}, 32'd1);
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic rsp_a(input logic [31:0] exp_rd, input logic exp_err);
    check_vec("a_rvalid", {31'd0, rv_a}, 32'd1);
    check_vec("a_err",    {31'd0, er_a}, {31'd0, exp_err});
    check_vec("a_rdata",  rd_a, exp_rd);
  endtask

  task automatic rsp_b(input logic [31:0] exp_rd, input logic exp_err);
    check_vec("b_rvalid", {31'd0, rv_b}, 32'd1);
    check_vec("b_err",    {31'd0, er_b}, {31'd0, exp_err});
    check_vec("b_rdata",  rd_b, exp_rd);
  endtask

  logic [31:0] exp_c [5];

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0; stall = 1'b0;

    // Reset then idle.
    tick();
    check_vec("rst_gnt",    {31'd0, gnt_a}, 32'd0);
    check_vec("rst_rvalid", {31'd0, rv_a},  32'd0);
    check_vec("rst_err",    {31'd0, er_a},  32'd0);
    check_vec("rst_rdata",  rd_a,           32'd0);
    check_vec("rst_rvalid_c", {31'd0, rv_c}, 32'd0);
    // Request during reset must not be granted.
    req = 1'b1;
    #1;
    check_vec("rst_gnt_req", {31'd0, gnt_a}, 32'd0);
    tick();
    check_vec("rst_rvalid2", {31'd0, rv_a}, 32'd0);
    check_vec("rst_rdata2",  rd_a,          32'd0);
    rst = 1'b0; req = 1'b0;
    tick();

    // Write then read back (latency 1).
    issue(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    rsp_a(32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    rsp_a(32'hDEAD_BEEF, 1'b0);

    // Partial write, then a be=0 no-op write.
    issue(1'b1, 4'hF, 32'h20, 32'h1122_3344);
    rsp_a(32'h0, 1'b0);
    issue(1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD);
    rsp_a(32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h20, 32'h0);
    rsp_a(32'h11BB_33DD, 1'b0);
    issue(1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF);
    rsp_a(32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h20, 32'h0);
    rsp_a(32'h11BB_33DD, 1'b0);
    tick();
    check_vec("idle_rvalid", {31'd0, rv_a}, 32'd0);
    check_vec("idle_rdata",  rd_a,          32'd0);

    // Stall three cycles with req held, then release with req still high.
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h10; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_vec("stall_gnt", {31'd0, gnt_a}, 32'd0);
      tick();
      check_vec("stall_rvalid", {31'd0, rv_a}, 32'd0);
    end
    stall = 1'b0;
    #1;
    check_vec("release_gnt", {31'd0, gnt_a}, 32'd1);
    tick();
    req = 1'b0;
    rsp_a(32'hDEAD_BEEF, 1'b0);

    // Address window on u_b (base 0x1000, 1024 words).
    issue(1'b1, 4'hF, 32'h1000, 32'h55AA_55AA);
    rsp_b(32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h2000, 32'h0);
    rsp_b(32'h0, 1'b1);
    issue(1'b0, 4'hF, 32'h0FFC, 32'h0);
    rsp_b(32'h0, 1'b1);
    issue(1'b1, 4'hF, 32'h2000, 32'hFFFF_FFFF);
    rsp_b(32'h0, 1'b1);
    issue(1'b0, 4'hF, 32'h1000, 32'h0);
    rsp_b(32'h55AA_55AA, 1'b0);
    issue(1'b1, 4'hF, 32'h1FFC, 32'h0BAD_F00D);
    rsp_b(32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h1FFC, 32'h0);
    rsp_b(32'h0BAD_F00D, 1'b0);

    // Latency 3 back-to-back: preload, drain, then 5 consecutive reads.
    for (int i = 0; i < 5; i++) begin
      exp_c[i] = 32'hC0DE_0000 + 32'(i);
      issue(1'b1, 4'hF, 32'(4 * i), exp_c[i]);
    end
    tick(); tick(); tick();
    for (int i = 0; i < 9; i++) begin
      if (i < 5) begin
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'(4 * i);
        #1;
        check_vec("b2b_gnt", {31'd0, gnt_c}, 32'd1);
      end else begin
        req = 1'b0; addr = 32'h0;
        #1;
      end
      if (i >= 3 && i < 8) begin
        check_vec("b2b_rvalid", {31'd0, rv_c}, 32'd1);
        check_vec("b2b_rdata",  rd_c, exp_c[i-3]);
        check_vec("b2b_err",    {31'd0, er_c}, 32'd0);
      end else begin
        check_vec("b2b_idle", {31'd0, rv_c}, 32'd0);
      end
      tick();
    end

    // Reset with two responses in flight; a write attempted during reset.
    issue(1'b0, 4'hF, 32'h0, 32'h0);
    issue(1'b0, 4'hF, 32'h4, 32'h0);
    rst = 1'b1; req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0; wdata = 32'hFFFF_FFFF;
    #1;
    check_vec("rst_mid_gnt", {31'd0, gnt_c}, 32'd0);
    tick();
    rst = 1'b0; req = 1'b0; we = 1'b0; wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check_vec("rst_flush", {31'd0, rv_c}, 32'd0);
      tick();
    end
    // Memory retained across reset.
    issue(1'b0, 4'hF, 32'h0, 32'h0);
    issue(1'b0, 4'hF, 32'h4, 32'h0);
    tick();
    check_vec("keep_rv0", {31'd0, rv_c}, 32'd1);
    check_vec("keep_rd0", rd_c, 32'hC0DE_0000);
    tick();
    check_vec("keep_rv1", {31'd0, rv_c}, 32'd1);
    check_vec("keep_rd1", rd_c, 32'hC0DE_0001);
    tick();
    check_vec("keep_idle", {31'd0, rv_c}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
